// File: rtl/cell_test_pkg.sv
// Cell IDs, test-set size and per-cell stimulus/compare properties for the testwafer sequencer.
package cell_test_pkg;

   localparam int NCELLS   = 19;
   localparam int SETTLE_W = 4;

   localparam logic [4:0] ID_AND2X1  = 5'd0;
   localparam logic [4:0] ID_AND2X2  = 5'd1;
   localparam logic [4:0] ID_AOI21X1 = 5'd2;
   localparam logic [4:0] ID_AOI22X1 = 5'd3;
   localparam logic [4:0] ID_BUFX2   = 5'd4;
   localparam logic [4:0] ID_HAX1    = 5'd5;
   localparam logic [4:0] ID_INV     = 5'd6;
   localparam logic [4:0] ID_INVX1   = 5'd7;
   localparam logic [4:0] ID_INVX2   = 5'd8;
   localparam logic [4:0] ID_INVX4   = 5'd9;
   localparam logic [4:0] ID_INVX8   = 5'd10;
   localparam logic [4:0] ID_MUX2X1  = 5'd11;
   localparam logic [4:0] ID_NAND2X1 = 5'd12;
   localparam logic [4:0] ID_NAND3X1 = 5'd13;
   localparam logic [4:0] ID_NOR2X1  = 5'd14;
   localparam logic [4:0] ID_OAI21X1 = 5'd15;
   localparam logic [4:0] ID_OAI22X1 = 5'd16;
   localparam logic [4:0] ID_OR2X1   = 5'd17;
   localparam logic [4:0] ID_XNOR2X1 = 5'd18;

   function automatic logic [2:0] cell_inputs(input logic [4:0] id);
      case (id)
         ID_BUFX2, ID_INV, ID_INVX1, ID_INVX2, ID_INVX4, ID_INVX8:   return 3'd1;
         ID_AOI21X1, ID_OAI21X1, ID_NAND3X1, ID_MUX2X1:              return 3'd3;
         ID_AOI22X1, ID_OAI22X1:                                     return 3'd4;
         default:                                                    return 3'd2;
      endcase
   endfunction

   // Only the half adder drives a second output worth comparing.
   function automatic logic [1:0] cell_mask(input logic [4:0] id);
      return (id == ID_HAX1) ? 2'b11 : 2'b01;
   endfunction

endpackage

// File: rtl/cell_golden_model.sv
// Combinational reference response of each test cell: bit0 = Y (YS), bit1 = YC (HAX1 only).
module cell_golden_model
   import cell_test_pkg::*;
(
   input  logic [4:0] cell_id,
   input  logic [3:0] vector,
   output logic [1:0] expected
);

   logic a, b, c, d;
   assign a = vector[0];
   assign b = vector[1];
   assign c = vector[2];
   assign d = vector[3];

   always_comb begin
      expected = 2'b00;
      case (cell_id)
         ID_AND2X1, ID_AND2X2:                                 expected[0] = a & b;
         ID_AOI21X1:                                           expected[0] = ~((a & b) | c);
         ID_AOI22X1:                                           expected[0] = ~((a & b) | (c & d));
         ID_BUFX2:                                             expected[0] = a;
         ID_HAX1:                                              expected    = {a & b, a ^ b};
         ID_INV, ID_INVX1, ID_INVX2, ID_INVX4, ID_INVX8:       expected[0] = ~a;
         ID_MUX2X1:                                            expected[0] = c ? b : a;
         ID_NAND2X1:                                           expected[0] = ~(a & b);
         ID_NAND3X1:                                           expected[0] = ~(a & b & c);
         ID_NOR2X1:                                            expected[0] = ~(a | b);
         ID_OAI21X1:                                           expected[0] = ~((a | b) & c);
         ID_OAI22X1:                                           expected[0] = ~((a | b) & (c | d));
         ID_OR2X1:                                             expected[0] = a | b;
         ID_XNOR2X1:                                           expected[0] = ~(a ^ b);
         default:                                              expected    = 2'b00;
      endcase
   end

endmodule

// File: rtl/cell_test_sequencer.sv
// Walks the selected cell through every input vector, compares against the golden model, reports errors.
// CELL_SEQ_LOG_EN adds fail_map_o, a per-vector mismatch bitmap.
module cell_test_sequencer
   import cell_test_pkg::*;
(
   input  logic                wb_clk_i,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [4:0]          cell_sel_i,
   input  logic [SETTLE_W-1:0] settle_i,
   output logic [3:0]          cut_in_o,
   output logic [NCELLS-1:0]   cut_en_o,
   input  logic [1:0]          cut_out_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                pass_o,
   output logic [4:0]          err_cnt_o,
   output logic [3:0]          first_fail_o,
   output logic                fail_valid_o
`ifdef CELL_SEQ_LOG_EN
   ,
   output logic [15:0]         fail_map_o
`endif
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_APPLY  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]          state;
   logic [4:0]          cell_id;
   logic [SETTLE_W-1:0] settle;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [3:0]          vector;
   logic [1:0]          expected;
   logic [4:0]          vec_span;
   logic                mismatch;
   logic                last_vec;

   cell_golden_model u_golden (
      .cell_id  (cell_id),
      .vector   (vector),
      .expected (expected)
   );

   assign vec_span = 5'd1 << cell_inputs(cell_id);
   assign last_vec = ({1'b0, vector} == (vec_span - 5'd1));
   assign mismatch = |((cut_out_i ^ expected) & cell_mask(cell_id));

   // Stimulus only reaches the pads while a vector is actually being exercised.
   assign busy_o   = (state == S_APPLY) || (state == S_SETTLE) || (state == S_SAMPLE);
   assign cut_in_o = busy_o ? vector : 4'd0;
   assign cut_en_o = busy_o ? ({{(NCELLS-1){1'b0}}, 1'b1} << cell_id) : '0;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cell_id      <= 5'd0;
         settle       <= '0;
         settle_cnt   <= '0;
         vector       <= 4'd0;
         done_o       <= 1'b0;
         pass_o       <= 1'b0;
         err_cnt_o    <= 5'd0;
         first_fail_o <= 4'd0;
         fail_valid_o <= 1'b0;
`ifdef CELL_SEQ_LOG_EN
         fail_map_o   <= 16'd0;
`endif
      end else begin
         done_o <= 1'b0;
         if (abort_i && (state != S_IDLE)) begin
            state  <= S_IDLE;
            pass_o <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_i && !abort_i) begin
                     cell_id      <= cell_sel_i;
                     settle       <= settle_i;
                     settle_cnt   <= '0;
                     vector       <= 4'd0;
                     pass_o       <= 1'b0;
                     err_cnt_o    <= 5'd0;
                     first_fail_o <= 4'd0;
                     fail_valid_o <= 1'b0;
`ifdef CELL_SEQ_LOG_EN
                     fail_map_o   <= 16'd0;
`endif
                     state <= (cell_sel_i < 5'(NCELLS)) ? S_APPLY : S_DONE;
                  end
               end
               S_APPLY: begin
                  settle_cnt <= settle;
                  state      <= (settle != '0) ? S_SETTLE : S_SAMPLE;
               end
               S_SETTLE: begin
                  settle_cnt <= settle_cnt - 1'b1;
                  if (settle_cnt == SETTLE_W'(1))
                     state <= S_SAMPLE;
               end
               S_SAMPLE: begin
                  if (mismatch) begin
                     err_cnt_o <= err_cnt_o + 5'd1;
                     if (!fail_valid_o) begin
                        first_fail_o <= vector;
                        fail_valid_o <= 1'b1;
                     end
`ifdef CELL_SEQ_LOG_EN
                     fail_map_o[vector] <= 1'b1;
`endif
                  end
                  if (last_vec) begin
                     state <= S_DONE;
                  end else begin
                     vector <= vector + 4'd1;
                     state  <= S_APPLY;
                  end
               end
               S_DONE: begin
                  done_o <= 1'b1;
                  pass_o <= (err_cnt_o == 5'd0) && (cell_id < 5'(NCELLS));
                  state  <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cell_test_sequencer.sv
// Bench for cell_test_sequencer: behavioural CUT + scoreboard, directed and randomized runs.
module tb_cell_test_sequencer;

   logic        wb_clk_i = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic        abort_i;
   logic [4:0]  cell_sel_i;
   logic [3:0]  settle_i;
   logic [3:0]  cut_in_o;
   logic [18:0] cut_en_o;
   logic [1:0]  cut_out_i;
   logic        busy_o;
   logic        done_o;
   logic        pass_o;
   logic [4:0]  err_cnt_o;
   logic [3:0]  first_fail_o;
   logic        fail_valid_o;
`ifdef CELL_SEQ_LOG_EN
   logic [15:0] fail_map_o;
`endif

   int errors = 0;
   int checks = 0;
   int cur_id = 0;
   int fault  = 0;
   logic [1:0] flip [16];

   always #5 wb_clk_i = ~wb_clk_i;

   cell_test_sequencer dut (
      .wb_clk_i     (wb_clk_i),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .cell_sel_i   (cell_sel_i),
      .settle_i     (settle_i),
      .cut_in_o     (cut_in_o),
      .cut_en_o     (cut_en_o),
      .cut_out_i    (cut_out_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .pass_o       (pass_o),
      .err_cnt_o    (err_cnt_o),
      .first_fail_o (first_fail_o),
      .fail_valid_o (fail_valid_o)
`ifdef CELL_SEQ_LOG_EN
      ,
      .fail_map_o   (fail_map_o)
`endif
   );

   // Number of inputs from the cell's name: INV/BUF 1, 3-input gates and MUX 3, 22-type 4, the rest 2.
   function automatic int n_in(input int id);
      case (id)
         4, 6, 7, 8, 9, 10: return 1;
         2, 11, 13, 15:     return 3;
         3, 16:             return 4;
         default:           return 2;
      endcase
   endfunction

   function automatic logic [1:0] mask_of(input int id);
      return (id == 5) ? 2'b11 : 2'b01;
   endfunction

   function automatic logic [1:0] ref_out(input int id, input logic [3:0] v);
      logic a, b, c, d;
      a = v[0]; b = v[1]; c = v[2]; d = v[3];
      case (id)
         0, 1:              return {1'b0, a & b};
         2:                 return {1'b0, !((a && b) || c)};
         3:                 return {1'b0, !((a && b) || (c && d))};
         4:                 return {1'b0, a};
         5:                 return {a & b, a ^ b};
         6, 7, 8, 9, 10:    return {1'b0, !a};
         11:                return {1'b0, c ? b : a};
         12:                return {1'b0, !(a && b)};
         13:                return {1'b0, !(a && b && c)};
         14:                return {1'b0, !(a || b)};
         15:                return {1'b0, !((a || b) && c)};
         16:                return {1'b0, !((a || b) && (c || d))};
         17:                return {1'b0, a | b};
         18:                return {1'b0, a == b};
         default:           return 2'b00;
      endcase
   endfunction

   // Fault modes of the simulated cell: 0 good, 1 Y stuck-at-1, 2 outputs swapped, 3 random flips.
   function automatic logic [1:0] cut_fn(input int f, input logic [1:0] g, input logic [1:0] fl);
      case (f)
         1:       return g | 2'b01;
         2:       return {g[0], g[1]};
         3:       return g ^ fl;
         default: return g;
      endcase
   endfunction

   always_comb cut_out_i = cut_fn(fault, ref_out(cur_id, cut_in_o), flip[cut_in_o]);

   task automatic run_test(input int id, input int s, input int f, input bit noisy, output int got_cyc);
      int nv, exp_cyc, exp_err, exp_ff;
      logic [15:0] exp_map;
      logic [1:0] gv, ov;
      logic [3:0] seen [$];
      nv      = 1 << n_in(id);
      exp_cyc = 1 + nv * (s + 2);
      exp_err = 0;
      exp_ff  = -1;
      exp_map = 16'd0;
      cur_id  = id;
      fault   = f;
      for (int v = 0; v < 16; v++) flip[v] = 2'($urandom_range(0, 3));
      for (int v = 0; v < nv; v++) begin
         gv = ref_out(id, 4'(v));
         ov = cut_fn(f, gv, flip[v]);
         if (((ov ^ gv) & mask_of(id)) != 2'b00) begin
            exp_err++;
            if (exp_ff < 0) exp_ff = v;
            exp_map[v] = 1'b1;
         end
      end

      @(negedge wb_clk_i);
      cell_sel_i = 5'(id);
      settle_i   = 4'(s);
      start_i    = 1'b1;
      @(posedge wb_clk_i); #1;
      start_i = 1'b0;
      got_cyc = -1;
      for (int c = 0; c < 2000; c++) begin
         if (done_o) begin
            got_cyc = c;
            break;
         end
         if (busy_o) begin
            checks++;
            if (cut_en_o !== (19'd1 << id)) begin
               errors++;
               $display("FAIL cut_en id=%0d cyc=%0d: got %h want %h", id, c, cut_en_o, 19'd1 << id);
            end
            if (seen.size() == 0 || seen[$] !== cut_in_o) seen.push_back(cut_in_o);
            if (noisy) begin
               start_i    = 1'($urandom_range(0, 1));
               cell_sel_i = 5'($urandom);
               settle_i   = 4'($urandom);
            end
         end else begin
            start_i = 1'b0;
         end
         @(posedge wb_clk_i); #1;
      end
      start_i = 1'b0;

      checks++;
      if (got_cyc !== exp_cyc) begin
         errors++;
         $display("FAIL done_cycle id=%0d s=%0d: got %0d want %0d (-1 = timeout)", id, s, got_cyc, exp_cyc);
      end
      checks++;
      if (pass_o !== (exp_err == 0)) begin
         errors++;
         $display("FAIL pass id=%0d: got %b want %b", id, pass_o, exp_err == 0);
      end
      checks++;
      if (err_cnt_o !== 5'(exp_err)) begin
         errors++;
         $display("FAIL err_cnt id=%0d f=%0d: got %0d want %0d", id, f, err_cnt_o, exp_err);
      end
      checks++;
      if (fail_valid_o !== (exp_err != 0)) begin
         errors++;
         $display("FAIL fail_valid id=%0d: got %b want %b", id, fail_valid_o, exp_err != 0);
      end
      if (exp_err != 0) begin
         checks++;
         if (first_fail_o !== 4'(exp_ff)) begin
            errors++;
            $display("FAIL first_fail id=%0d: got %0d want %0d", id, first_fail_o, exp_ff);
         end
      end
`ifdef CELL_SEQ_LOG_EN
      checks++;
      if (fail_map_o !== exp_map) begin
         errors++;
         $display("FAIL fail_map id=%0d: got %h want %h", id, fail_map_o, exp_map);
      end
`endif
      checks++;
      if (busy_o !== 1'b0 || cut_en_o !== '0) begin
         errors++;
         $display("FAIL idle_after_done id=%0d: busy %b en %h want 0 0", id, busy_o, cut_en_o);
      end
      checks++;
      begin
         bit seq_ok;
         seq_ok = (seen.size() == nv);
         for (int i = 0; i < seen.size(); i++) if (seen[i] !== 4'(i)) seq_ok = 0;
         if (!seq_ok) begin
            errors++;
            $display("FAIL vector_seq id=%0d: got %0d distinct vectors want 0..%0d in order", id, seen.size(), nv - 1);
         end
      end
      @(posedge wb_clk_i); #1;
      checks++;
      if (done_o !== 1'b0 || err_cnt_o !== 5'(exp_err)) begin
         errors++;
         $display("FAIL done_pulse_hold id=%0d: done %b err %0d want 0 %0d", id, done_o, err_cnt_o, exp_err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; cell_sel_i = 5'd0; settle_i = 4'd0;
      repeat (2) @(posedge wb_clk_i);
      #1;
      checks++;
      if ({busy_o, done_o, pass_o, err_cnt_o, first_fail_o, fail_valid_o, cut_en_o, cut_in_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy %b done %b pass %b err %0d en %h in %h want all 0",
                  busy_o, done_o, pass_o, err_cnt_o, cut_en_o, cut_in_o);
      end
      @(negedge wb_clk_i); rst_n = 1'b1;
      @(posedge wb_clk_i); #1;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || cut_en_o !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: busy %b done %b en %h want 0 0 0", busy_o, done_o, cut_en_o);
      end
   endtask

   task automatic test_directed();
      int c;
      run_test(6, 2, 0, 0, c);
      checks++;
      if (c !== 9 || pass_o !== 1'b1) begin
         errors++; $display("FAIL inv_run: cycle %0d pass %b want 9 1", c, pass_o);
      end
      run_test(13, 1, 1, 0, c);
      checks++;
      if (c !== 25 || err_cnt_o !== 5'd1 || first_fail_o !== 4'd7) begin
         errors++; $display("FAIL nand3_stuck: cycle %0d err %0d ff %0d want 25 1 7", c, err_cnt_o, first_fail_o);
      end
      run_test(5, 0, 2, 0, c);
      checks++;
      if (err_cnt_o !== 5'd3 || first_fail_o !== 4'd1) begin
         errors++; $display("FAIL hax_swap: err %0d ff %0d want 3 1", err_cnt_o, first_fail_o);
      end
      run_test(16, 0, 0, 1, c);
      checks++;
      if (c !== 33 || pass_o !== 1'b1) begin
         errors++; $display("FAIL oai22_run: cycle %0d pass %b want 33 1", c, pass_o);
      end
   endtask

   task automatic test_random();
      int c;
      repeat (24) begin
         run_test($urandom_range(0, 18), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), c);
      end
   endtask

   task automatic test_abort();
      int stray;
      cur_id = 11; fault = 1;
      @(negedge wb_clk_i);
      cell_sel_i = 5'd11; settle_i = 4'd2; start_i = 1'b1;
      @(posedge wb_clk_i); #1;
      start_i = 1'b0;
      repeat (9) begin @(posedge wb_clk_i); #1; end
      abort_i = 1'b1; start_i = 1'b1;
      @(posedge wb_clk_i); #1;
      checks++;
      if (busy_o !== 1'b0 || cut_en_o !== '0 || done_o !== 1'b0 || pass_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_stop: busy %b en %h done %b pass %b want 0 0 0 0", busy_o, cut_en_o, done_o, pass_o);
      end
      checks++;
      if (err_cnt_o !== 5'd1 || first_fail_o !== 4'd0 || fail_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL abort_partial: err %0d ff %0d fv %b want 1 0 1", err_cnt_o, first_fail_o, fail_valid_o);
      end
      @(posedge wb_clk_i); #1;
      abort_i = 1'b0; start_i = 1'b0;
      stray = 0;
      repeat (40) begin
         if (busy_o || done_o) stray++;
         @(posedge wb_clk_i); #1;
      end
      checks++;
      if (stray != 0) begin
         errors++; $display("FAIL abort_no_restart: got %0d busy/done cycles want 0", stray);
      end
   endtask

   task automatic test_invalid();
      int en_seen;
      en_seen = 0;
      @(negedge wb_clk_i);
      cell_sel_i = 5'd25; settle_i = 4'd3; start_i = 1'b1;
      @(posedge wb_clk_i); #1;
      start_i = 1'b0;
      if (cut_en_o !== '0 || busy_o) en_seen++;
      @(posedge wb_clk_i); #1;
      checks++;
      if (done_o !== 1'b1 || pass_o !== 1'b0 || err_cnt_o !== 5'd0) begin
         errors++;
         $display("FAIL invalid_id: done %b pass %b err %0d want 1 0 0", done_o, pass_o, err_cnt_o);
      end
      repeat (5) begin
         if (cut_en_o !== '0 || busy_o) en_seen++;
         @(posedge wb_clk_i); #1;
      end
      checks++;
      if (en_seen != 0) begin
         errors++; $display("FAIL invalid_no_enable: got %0d enabled cycles want 0", en_seen);
      end
   endtask

   task automatic test_reset_mid();
      cur_id = 16; fault = 0;
      @(negedge wb_clk_i);
      cell_sel_i = 5'd16; settle_i = 4'd0; start_i = 1'b1;
      @(posedge wb_clk_i); #1;
      start_i = 1'b0;
      repeat (5) begin @(posedge wb_clk_i); #1; end
      checks++;
      if (busy_o !== 1'b1) begin
         errors++; $display("FAIL mid_run_busy: got %b want 1", busy_o);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy_o, done_o, pass_o, err_cnt_o, first_fail_o, fail_valid_o, cut_en_o, cut_in_o} !== '0) begin
         errors++;
         $display("FAIL async_reset: busy %b en %h in %h err %0d want all 0", busy_o, cut_en_o, cut_in_o, err_cnt_o);
      end
      @(negedge wb_clk_i); rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_abort();
      test_invalid();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
